// File: rtl/bsg_dlatch_pkg.sv
// Shared types and helpers for the bsg_dlatch write-control slice.
package bsg_dlatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int lg_els(input int els);
        return (els > 2) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_dlatch_wr_rr_arb.sv
// Round-robin arbiter: combinational grant from v_i and the priority pointer,
// pointer advances past the winner on each advance_i strobe.
module bsg_dlatch_wr_rr_arb
    import bsg_dlatch_pkg::*;
#(
    parameter  int num_req_p = 4,
    localparam int lg_req_lp = lg_els(num_req_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] v_i,
    input  logic                 advance_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [lg_req_lp-1:0] grant_id_o
);

    logic [lg_req_lp-1:0] ptr_reg;
    logic [lg_req_lp-1:0] ptr_next;
    logic                 found;
    int                   cand;

    // Scan from the pointer upwards, wrapping, and take the first valid requester.
    always_comb begin
        found      = 1'b0;
        cand       = 0;
        grant_id_o = '0;
        for (int k = 0; k < num_req_p; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= num_req_p) begin
                cand = cand - num_req_p;
            end
            if (!found && v_i[cand]) begin
                found      = 1'b1;
                grant_id_o = lg_req_lp'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_grant
            assign grant_o[gi] = found && (grant_id_o == lg_req_lp'(gi));
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (advance_i) begin
            ptr_next = (grant_id_o == lg_req_lp'(num_req_p - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/bsg_dlatch_wr_ctrl.sv
// Shared write sequencer for a latch-based register file: arbitrates requesters
// and turns each write into a setup / one-cycle flop-driven enable / hold sequence.
module bsg_dlatch_wr_ctrl
    import bsg_dlatch_pkg::*;
#(
    parameter  int width_p   = 64,
    parameter  int els_p     = 8,
    parameter  int num_req_p = 4,
    localparam int lg_els_lp = lg_els(els_p),
    localparam int lg_req_lp = lg_els(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*lg_els_lp-1:0] req_addr_i,
    input  logic [num_req_p*width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic [els_p-1:0]               latch_en_o,
    output logic [width_p-1:0]             latch_data_o,
    output logic                           busy_o,
    output logic                           addr_err_o
);

    localparam logic [lg_els_lp:0] els_lim_lp = (lg_els_lp + 1)'(els_p);

    wr_state_e              state_reg;
    wr_state_e              state_next;
    logic [num_req_p-1:0]   grant;
    logic [lg_req_lp-1:0]   grant_id;
    logic                   accept_window;
    logic                   accept;
    logic [lg_els_lp-1:0]   addr_arr [num_req_p];
    logic [width_p-1:0]     data_arr [num_req_p];
    logic [lg_els_lp-1:0]   sel_addr;
    logic [width_p-1:0]     sel_data;
    logic                   addr_oob;
    logic [lg_els_lp-1:0]   addr_reg;
    logic [width_p-1:0]     data_reg;
    logic [els_p-1:0]       en_reg;
    logic [els_p-1:0]       en_next;
    logic [els_p-1:0]       dec;
    logic                   err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_i[gi*lg_els_lp +: lg_els_lp];
            assign data_arr[gi] = req_data_i[gi*width_p +: width_p];
        end
        // Out-of-range addresses match no word, so the enable stays low for them.
        for (gi = 0; gi < els_p; gi++) begin : g_decode
            assign dec[gi] = (addr_reg == lg_els_lp'(gi));
        end
    endgenerate

    // Yumi is masked while in reset so nothing is consumed before the flops settle.
    assign accept_window = reset_n_i && ((state_reg == IDLE) || (state_reg == HOLD));
    assign accept        = accept_window && (|req_v_i);
    assign req_yumi_o    = accept_window ? grant : '0;

    assign sel_addr = addr_arr[grant_id];
    assign sel_data = data_arr[grant_id];
    assign addr_oob = ({1'b0, sel_addr} >= els_lim_lp);

    bsg_dlatch_wr_rr_arb #(
        .num_req_p (num_req_p)
    ) arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .v_i        (req_v_i),
        .advance_i  (accept),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    always_comb begin
        state_next = state_reg;
        en_next    = '0;
        unique case (state_reg)
            IDLE:    state_next = accept ? SETUP : IDLE;
            SETUP: begin
                state_next = OPEN;
                en_next    = dec;
            end
            OPEN:    state_next = HOLD;
            HOLD:    state_next = accept ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            en_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            en_reg    <= en_next;
            if (accept) begin
                addr_reg <= sel_addr;
                data_reg <= sel_data;
                if (addr_oob) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign latch_en_o   = en_reg;
    assign latch_data_o = data_reg;
    assign busy_o       = (state_reg != IDLE);
    assign addr_err_o   = err_reg;

endmodule

// File: tb/tb_bsg_dlatch_wr_ctrl.sv
// Self-checking bench for bsg_dlatch_wr_ctrl: per-cycle vector table plus a
// write scoreboard for enable/data, and a hand sequence for mid-OPEN reset.
module tb_bsg_dlatch_wr_ctrl;

    // Six words so that a 3-bit address can point past the end of the array.
    localparam int W   = 64;
    localparam int ELS = 6;
    localparam int NR  = 4;
    localparam int LG  = 3;
    localparam int NV  = 44;

    localparam logic [11:0] AD = {3'd0, 3'd5, 3'd1, 3'd3};
    localparam logic [11:0] AE = {3'd0, 3'd5, 3'd7, 3'd3};

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_v;
    logic [NR*LG-1:0]  req_addr;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_yumi;
    logic [ELS-1:0]    latch_en;
    logic [W-1:0]      latch_data;
    logic              busy;
    logic              addr_err;

    always #5 clk = ~clk;

    bsg_dlatch_wr_ctrl #(
        .width_p   (W),
        .els_p     (ELS),
        .num_req_p (NR)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_yumi_o   (req_yumi),
        .latch_en_o   (latch_en),
        .latch_data_o (latch_data),
        .busy_o       (busy),
        .addr_err_o   (addr_err)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  yumi;
        logic        busy;
        logic        err;
        logic [11:0] addrs;
    } vec_t;

    typedef struct {
        int             due;
        logic [ELS-1:0] en;
        logic [W-1:0]   data;
    } sb_t;

    vec_t         vecs [NV];
    sb_t          sb_q [$];
    int           gen  [NR];
    logic [W-1:0] exp_data;
    int           n_checks;
    int           n_pass;

    function automatic logic [W-1:0] wdata(input int i, input int g);
        return {32'hDEAD_BEEF, 8'(i), 24'(g + 1)};
    endfunction

    function automatic logic [ELS-1:0] exp_en(input logic [LG-1:0] a);
        logic [ELS-1:0] r;
        r = '0;
        if (int'(a) < ELS) r[a] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] y,
                                input logic b, input logic e, input logic [11:0] a);
        vec_t r;
        r.v = v; r.yumi = y; r.busy = b; r.err = e; r.addrs = a;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] v, input logic [11:0] a);
        req_v    = v;
        req_addr = a;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = wdata(i, gen[i]);
    endtask

    task automatic run_row(input int r);
        vec_t t;
        sb_t  e;
        t = vecs[r];
        @(negedge clk);
        drive(t.v, t.addrs);
        #1;
        chk($sformatf("yumi row%0d", r), W'(req_yumi), W'(t.yumi));
        chk($sformatf("busy row%0d", r), W'(busy), W'(t.busy));
        chk($sformatf("addr_err row%0d", r), W'(addr_err), W'(t.err));
        chk($sformatf("data row%0d", r), latch_data, exp_data);
        if (sb_q.size() > 0 && sb_q[0].due == r) begin
            e = sb_q.pop_front();
            chk($sformatf("en row%0d", r), W'(latch_en), W'(e.en));
            chk($sformatf("en_data row%0d", r), latch_data, e.data);
        end else begin
            chk($sformatf("en_idle row%0d", r), W'(latch_en), W'(0));
        end
        for (int i = 0; i < NR; i++) begin
            if (t.yumi[i]) begin
                e.due  = r + 2;
                e.en   = exp_en(t.addrs[i*LG +: LG]);
                e.data = wdata(i, gen[i]);
                sb_q.push_back(e);
                exp_data = e.data;
                $display("row %0d: write req%0d addr %0d data %h", r, i,
                         t.addrs[i*LG +: LG], e.data);
                gen[i]++;
            end
        end
    endtask

    initial begin
        logic [W-1:0] hold_data;
        n_checks = 0;
        n_pass   = 0;
        exp_data = '0;
        for (int i = 0; i < NR; i++) gen[i] = 0;

        // v, expected yumi, busy, addr_err, addresses
        vecs[0]  = mk(4'b0001, 4'b0001, 0, 0, AD);
        vecs[1]  = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[2]  = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[3]  = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[4]  = mk(4'b0000, 4'b0000, 0, 0, AD);
        vecs[5]  = mk(4'b1111, 4'b0010, 0, 0, AD);
        vecs[6]  = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[7]  = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[8]  = mk(4'b1111, 4'b0100, 1, 0, AD);
        vecs[9]  = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[10] = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[11] = mk(4'b1111, 4'b1000, 1, 0, AD);
        vecs[12] = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[13] = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[14] = mk(4'b1111, 4'b0001, 1, 0, AD);
        vecs[15] = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[16] = mk(4'b1111, 4'b0000, 1, 0, AD);
        vecs[17] = mk(4'b1111, 4'b0010, 1, 0, AD);
        vecs[18] = mk(4'b1010, 4'b0000, 1, 0, AD);
        vecs[19] = mk(4'b1010, 4'b0000, 1, 0, AD);
        vecs[20] = mk(4'b1010, 4'b1000, 1, 0, AD);
        vecs[21] = mk(4'b0010, 4'b0000, 1, 0, AD);
        vecs[22] = mk(4'b0010, 4'b0000, 1, 0, AD);
        vecs[23] = mk(4'b0010, 4'b0010, 1, 0, AD);
        vecs[24] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[25] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[26] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[27] = mk(4'b0000, 4'b0000, 0, 0, AD);
        vecs[28] = mk(4'b0100, 4'b0100, 0, 0, AD);
        vecs[29] = mk(4'b0001, 4'b0000, 1, 0, AD);
        vecs[30] = mk(4'b0001, 4'b0000, 1, 0, AD);
        vecs[31] = mk(4'b0001, 4'b0001, 1, 0, AD);
        vecs[32] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[33] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[34] = mk(4'b0000, 4'b0000, 1, 0, AD);
        vecs[35] = mk(4'b0000, 4'b0000, 0, 0, AD);
        vecs[36] = mk(4'b0010, 4'b0010, 0, 0, AE);
        vecs[37] = mk(4'b0000, 4'b0000, 1, 1, AE);
        vecs[38] = mk(4'b0000, 4'b0000, 1, 1, AE);
        vecs[39] = mk(4'b0100, 4'b0100, 1, 1, AD);
        vecs[40] = mk(4'b0000, 4'b0000, 1, 1, AD);
        vecs[41] = mk(4'b0000, 4'b0000, 1, 1, AD);
        vecs[42] = mk(4'b0000, 4'b0000, 1, 1, AD);
        vecs[43] = mk(4'b0000, 4'b0000, 0, 1, AD);

        reset_n = 1'b0;
        drive(4'b1111, AD);
        #2;
        chk("reset yumi", W'(req_yumi), W'(0));
        chk("reset en", W'(latch_en), W'(0));
        chk("reset data", latch_data, W'(0));
        chk("reset busy", W'(busy), W'(0));
        chk("reset addr_err", W'(addr_err), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b0000, AD);

        for (int r = 0; r < NV; r++) run_row(r);
        chk("scoreboard drained", W'(sb_q.size()), W'(0));

        // Reset asserted in the middle of an OPEN cycle, pointer parked at 3.
        @(negedge clk);
        drive(4'b0100, AD);
        #1;
        chk("pre-reset yumi", W'(req_yumi), W'(4'b0100));
        hold_data = wdata(2, gen[2]);
        gen[2]++;
        @(negedge clk);
        drive(4'b0000, AD);
        #1;
        chk("pre-reset busy", W'(busy), W'(1));
        @(negedge clk);
        #1;
        chk("open en", W'(latch_en), W'(6'h20));
        chk("open data", latch_data, hold_data);
        #1;
        reset_n = 1'b0;
        drive(4'b1111, AD);
        #1;
        chk("async rst en", W'(latch_en), W'(0));
        chk("async rst data", latch_data, W'(0));
        chk("async rst busy", W'(busy), W'(0));
        chk("async rst yumi", W'(req_yumi), W'(0));
        chk("async rst addr_err", W'(addr_err), W'(0));
        @(negedge clk);
        #1;
        chk("in rst yumi", W'(req_yumi), W'(0));
        chk("in rst busy", W'(busy), W'(0));
        #1;
        reset_n = 1'b1;
        #1;
        chk("post-reset grant", W'(req_yumi), W'(4'b0001));
        @(negedge clk);
        drive(4'b0000, AD);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
